seed_rom_loader: RTL and testbench

- Parametrised successor to the fixed 32-bit / 7168-bit seed reader.
- Streams SEED_W/DATA_W consecutive words from a synchronous ROM starting at a programmable base address and assembles them into one wide Toeplitz seed register.
- Presents the seed to the shift stage with a valid/ack handshake.
- Supports configurable ROM read latency, re-triggerable loads and address wrap-around.

---
 rtl/seed_loader_pkg.sv | 25 ++
 rtl/seed_capture_pipe.sv | 40 ++++
 rtl/seed_rom_loader.sv | 160 ++++++++++++++++
 tb/tb_seed_rom_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_loader_pkg.sv
// Shared definitions for the seed ROM loader: FSM encoding, word-count
// helpers and the supported ROM latency bound.
package seed_loader_pkg;

  localparam int STATE_W     = 2;
  localparam int ROM_LAT_MAX = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  // Number of ROM words that make up one seed.
  function automatic int calc_nwords(input int seed_w, input int data_w);
    return seed_w / data_w;
  endfunction

  // Width of a word index; a single-word seed still gets a 1-bit index.
  function automatic int calc_idx_w(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/seed_capture_pipe.sv
// Tracks outstanding ROM reads: a LAT-deep shift register of {valid, word
// index} whose tail lines up with the cycle the ROM data is on the bus.
module seed_capture_pipe
  import seed_loader_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int IDX_W = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [LAT-1:0]   r_vld;
  logic [IDX_W-1:0] r_idx [LAT];

  // Shift issue tags toward the capture point; reset discards reads in flight
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_idx[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_idx[0] <= i_idx;
      for (int k = 1; k < LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_idx[k] <= r_idx[k-1];
      end
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_idx   = r_idx[LAT-1];

endmodule

// File: rtl/seed_rom_loader.sv
// Streams SEED_W/DATA_W consecutive ROM words from a programmable base
// address into one wide seed register and offers it with a valid/ack
// handshake. Optional XOR parity of the captured words is enabled by
// defining SEED_ROM_LOADER_PARITY_EN.
module seed_rom_loader
  import seed_loader_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SEED_W  = 7168,
  parameter int ADDR_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [SEED_W-1:0] seed,
  output logic              seed_valid,
  input  logic              seed_ack,
  output logic              busy
`ifdef SEED_ROM_LOADER_PARITY_EN
  ,
  output logic [DATA_W-1:0] seed_parity
`endif
);

  localparam int NWORDS = calc_nwords(SEED_W, DATA_W);
  localparam int IDX_W  = calc_idx_w(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  // Reject configurations the datapath cannot represent
  if ((SEED_W % DATA_W) != 0 || NWORDS < 1) begin : g_bad_width
    $error("seed_rom_loader: SEED_W must be a positive multiple of DATA_W");
  end
  if (ROM_LAT < 1 || ROM_LAT > ROM_LAT_MAX) begin : g_bad_lat
    $error("seed_rom_loader: ROM_LAT out of range 1..4");
  end

  state_t            r_state;
  logic              r_rom_en;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [IDX_W-1:0]  r_issue_idx;
  logic              r_seed_valid;
  logic              r_busy;
  logic [DATA_W-1:0] r_words [NWORDS];

  logic              w_cap_valid;
  logic [IDX_W-1:0]  w_cap_idx;
  logic              w_accept;

  assign w_accept = (r_state == ST_IDLE) && start;

  seed_capture_pipe #(
    .LAT   (ROM_LAT),
    .IDX_W (IDX_W)
  ) u_capture_pipe (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_valid (r_rom_en),
    .i_idx   (r_issue_idx),
    .o_valid (w_cap_valid),
    .o_idx   (w_cap_idx)
  );

  // Control FSM: issue NWORDS addresses, wait for the last capture, hold until ack
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rom_en     <= 1'b0;
      r_rom_addr   <= '0;
      r_issue_idx  <= '0;
      r_seed_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_FETCH;
            r_rom_en    <= 1'b1;
            r_rom_addr  <= base_addr;
            r_issue_idx <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (r_issue_idx == LAST_IDX) begin
            r_rom_en <= 1'b0;
            r_state  <= ST_DRAIN;
          end else begin
            // Address arithmetic wraps naturally at 2^ADDR_W
            r_rom_addr  <= r_rom_addr + ADDR_W'(1);
            r_issue_idx <= r_issue_idx + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          // Valid rises together with the final word landing in the seed
          if (w_cap_valid && (w_cap_idx == LAST_IDX)) begin
            r_seed_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_VALID;
          end
        end
        ST_VALID: begin
          // A start arriving with the ack is dropped by design
          if (seed_ack) begin
            r_seed_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Seed assembly: clear on a new load, then write each word at its index
  always_ff @(posedge clk_in) begin
    if (rst || w_accept) begin
      for (int k = 0; k < NWORDS; k++) begin
        r_words[k] <= '0;
      end
    end else if (w_cap_valid) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (w_cap_idx == IDX_W'(k)) begin
          r_words[k] <= rom_data;
        end
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NWORDS; gi++) begin : g_seed_map
    assign seed[gi*DATA_W +: DATA_W] = r_words[gi];
  end

`ifdef SEED_ROM_LOADER_PARITY_EN
  logic [DATA_W-1:0] r_parity;

  // Running XOR of every captured word, restarted with each load
  always_ff @(posedge clk_in) begin
    if (rst || w_accept) begin
      r_parity <= '0;
    end else if (w_cap_valid) begin
      r_parity <= r_parity ^ rom_data;
    end
  end

  assign seed_parity = r_parity;
`endif

  assign rom_en     = r_rom_en;
  assign rom_addr   = r_rom_addr;
  assign seed_valid = r_seed_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_seed_rom_loader.sv
// Bench for seed_rom_loader: two instances (ROM_LAT=1 and ROM_LAT=3) with
// SEED_W=128/DATA_W=32, each fed by a latency-matched ROM model whose word
// at address a is 32'hA5A50000|a. Define SEED_ROM_LOADER_PARITY_EN to
// also check seed_parity.
module tb_seed_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            rst;
  logic [1:0]            start;
  logic [1:0][7:0]       base_addr;
  logic [1:0]            rom_en;
  logic [1:0][7:0]       rom_addr;
  logic [1:0][31:0]      rom_data;
  logic [1:0][127:0]     seed;
  logic [1:0]            seed_valid;
  logic [1:0]            seed_ack;
  logic [1:0]            busy;
`ifdef SEED_ROM_LOADER_PARITY_EN
  logic [1:0][31:0]      seed_parity;
`endif

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return 32'hA5A5_0000 | {24'h0, a};
  endfunction

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_unit
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] pipe [4];

    // Synchronous ROM with LAT cycles from registered address to data
    always @(posedge clk) begin
      pipe[0] <= rom_en[gi] ? rom_word(rom_addr[gi]) : 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign rom_data[gi] = pipe[LAT-1];

    seed_rom_loader #(
      .DATA_W (32),
      .SEED_W (128),
      .ADDR_W (8),
      .ROM_LAT(LAT)
    ) u_dut (
      .clk_in     (clk),
      .rst        (rst[gi]),
      .start      (start[gi]),
      .base_addr  (base_addr[gi]),
      .rom_en     (rom_en[gi]),
      .rom_addr   (rom_addr[gi]),
      .rom_data   (rom_data[gi]),
      .seed       (seed[gi]),
      .seed_valid (seed_valid[gi]),
      .seed_ack   (seed_ack[gi]),
      .busy       (busy[gi])
`ifdef SEED_ROM_LOADER_PARITY_EN
      ,
      .seed_parity(seed_parity[gi])
`endif
    );
  end

  typedef struct {
    int           u;
    logic [7:0]   base;
    int           lat;
    logic [127:0] seed;
    int           poke_cyc;
  } vec_t;

  typedef struct {
    logic [127:0] seed;
    logic [31:0]  par;
    int           lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] addr_q[$];
  int         cyc_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_par(input logic [7:0] b);
    logic [31:0] p = '0;
    for (int k = 0; k < 4; k++) p ^= rom_word(b + 8'(k));
    return p;
  endfunction

  // One full load; poke_cyc > 0 drives a stray ack and start in that cycle
  task automatic run_load(input int u, input logic [7:0] b, input int exp_lat,
                          input logic [127:0] exp_seed, input int poke_cyc);
    exp_t       e;
    int         cyc;
    bit         done;
    logic [7:0] a;
    int         c;
    e.seed = exp_seed;
    e.par  = model_par(b);
    e.lat  = exp_lat;
    sb_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      addr_q.push_back(b + 8'(k));
      cyc_q.push_back(k + 1);
    end
    start[u]     = 1'b1;
    base_addr[u] = b;
    tick();
    start[u] = 1'b0;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc <= 40) begin
      if (rom_en[u]) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_issue: rom_en high in cycle %0d, expected low after cycle 4", cyc);
        end else begin
          a = addr_q.pop_front();
          c = cyc_q.pop_front();
          chk("rom_addr", 128'(rom_addr[u]), 128'(a));
          chk("issue_cycle", 128'(cyc), 128'(c));
        end
      end
      chk("busy", 128'(busy[u]), 128'(cyc < exp_lat));
      if (seed_valid[u]) begin
        e = sb_q.pop_front();
        chk("valid_cycle", 128'(cyc), 128'(e.lat));
        chk("seed", seed[u], e.seed);
`ifdef SEED_ROM_LOADER_PARITY_EN
        chk("seed_parity", 128'(seed_parity[u]), 128'(e.par));
`endif
        done = 1'b1;
      end else begin
        seed_ack[u] = (cyc == poke_cyc);
        start[u]    = (cyc == poke_cyc);
        base_addr[u] = (cyc == poke_cyc) ? 8'h99 : b;
        tick();
        cyc++;
      end
    end
    seed_ack[u] = 1'b0;
    start[u]    = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: unit %0d no seed_valid within 40 cycles, expected cycle %0d", u, exp_lat);
      void'(sb_q.pop_front());
    end
    if (addr_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_issue: %0d addresses not issued, expected 0", addr_q.size());
    end
    addr_q.delete();
    cyc_q.delete();
    $display("load unit=%0d base=%h valid_cycle=%0d seed=%h", u, b, cyc, seed[u]);
  endtask

  // Acknowledge the seed, optionally with a simultaneous start that must be dropped
  task automatic do_ack(input int u, input logic [127:0] exp_seed, input bit with_start);
    seed_ack[u] = 1'b1;
    if (with_start) begin
      start[u]     = 1'b1;
      base_addr[u] = 8'h40;
    end
    tick();
    seed_ack[u] = 1'b0;
    start[u]    = 1'b0;
    chk("ack_valid_low", 128'(seed_valid[u]), 128'(0));
    chk("ack_busy_low", 128'(busy[u]), 128'(0));
    chk("seed_held_idle", seed[u], exp_seed);
    tick();
    chk("ack_start_dropped", 128'({rom_en[u], busy[u]}), 128'(0));
    $display("ack unit=%0d with_start=%0d seed_valid=%0d rom_en=%0d", u, with_start, seed_valid[u], rom_en[u]);
  endtask

  task automatic reset_mid(input int u, input logic [7:0] b, input int at_cyc);
    bit saw;
    start[u]     = 1'b1;
    base_addr[u] = b;
    tick();
    start[u] = 1'b0;
    for (int c = 1; c < at_cyc; c++) tick();
    rst[u] = 1'b1;
    tick();
    rst[u] = 1'b0;
    chk("rst_rom_en", 128'(rom_en[u]), 128'(0));
    chk("rst_seed", seed[u], 128'(0));
    chk("rst_busy", 128'(busy[u]), 128'(0));
    saw = 1'b0;
    repeat (12) begin
      tick();
      if (seed_valid[u] || rom_en[u]) saw = 1'b1;
    end
    chk("no_activity_after_rst", 128'(saw), 128'(0));
    $display("reset unit=%0d base=%h at_cycle=%0d", u, b, at_cyc);
  endtask

  localparam logic [127:0] S10 = 128'hA5A50013_A5A50012_A5A50011_A5A50010;
  localparam logic [127:0] SFE = 128'hA5A50001_A5A50000_A5A500FF_A5A500FE;
  localparam logic [127:0] SFF = 128'hA5A50002_A5A50001_A5A50000_A5A500FF;
  localparam logic [127:0] S7F = 128'hA5A50082_A5A50081_A5A50080_A5A5007F;
  localparam logic [127:0] S11 = 128'hA5A50014_A5A50013_A5A50012_A5A50011;

  initial begin
    vec_t vecs[5];
    vecs[0] = '{0, 8'h10, 6, S10, 0};
    vecs[1] = '{1, 8'hFE, 8, SFE, 3};
    vecs[2] = '{0, 8'hFF, 6, SFF, 2};
    vecs[3] = '{1, 8'h7F, 8, S7F, 0};
    vecs[4] = '{0, 8'h11, 6, S11, 0};

    rst       = 2'b11;
    start     = '0;
    base_addr = '0;
    seed_ack  = '0;

    // Reset held for three cycles with no start
    repeat (3) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        chk("reset_rom_en", 128'(rom_en[u]), 128'(0));
        chk("reset_seed", seed[u], 128'(0));
        chk("reset_valid", 128'(seed_valid[u]), 128'(0));
        chk("reset_busy", 128'(busy[u]), 128'(0));
      end
    end
    rst = 2'b00;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].u, vecs[i].base, vecs[i].lat, vecs[i].seed, vecs[i].poke_cyc);
      do_ack(vecs[i].u, vecs[i].seed, 1'b0);
    end

    // Handshake: seed held for 20 cycles without ack while starts are ignored
    run_load(0, 8'h10, 6, S10, 0);
    for (int c = 0; c < 20; c++) begin
      start[0]     = c[0];
      base_addr[0] = 8'h55;
      tick();
      chk("hold_seed", seed[0], S10);
      chk("hold_valid", 128'(seed_valid[0]), 128'(1));
      chk("hold_rom_en", 128'(rom_en[0]), 128'(0));
    end
    start[0] = 1'b0;
    do_ack(0, S10, 1'b1);
    run_load(0, 8'h11, 6, S11, 0);
    do_ack(0, S11, 1'b0);

    // Reset in the middle of loads, then a clean reload
    reset_mid(0, 8'h10, 2);
    run_load(0, 8'h10, 6, S10, 0);
    do_ack(0, S10, 1'b0);
    reset_mid(1, 8'hFE, 5);
    run_load(1, 8'hFE, 8, SFE, 0);
    do_ack(1, SFE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
